// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   - state_e              : fetch FSM states
//   - RESET_VECTOR_DEFAULT : default PC driven while reset is asserted
//   - PC_STEP_DEFAULT      : default byte increment for sequential fetch
//   - ALIGN_MASK           : clears bits [1:0] of redirect targets
//   - align_target()       : applies ALIGN_MASK to a redirect target
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEFAULT      = 32'd4;
  localparam logic [31:0] ALIGN_MASK           = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_target(input logic [31:0] target);
    return target & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/next_pc_select.sv
// Next-PC priority mux for the fetch sequencer (purely combinational).
// Ports:
//   rst, flush, consume       : redirect qualifiers, highest priority first
//   jump, branch_taken        : only honoured while consume is high
//   flush_target, jump_target,
//   branch_target             : redirect destinations (aligned here)
//   pc                        : current PC from the PC register
//   newpc                     : value the PC register loads on the next edge
module next_pc_select
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] PC_STEP      = PC_STEP_DEFAULT
) (
  input  logic        rst,
  input  logic        flush,
  input  logic        consume,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [31:0] flush_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] branch_target,
  input  logic [31:0] pc,
  output logic [31:0] newpc
);

  // Priority select; the PC register reloads every cycle, so "hold" means newpc = pc.
  always_comb begin
    newpc = pc;
    if (rst) begin
      newpc = RESET_VECTOR;
    end else if (flush) begin
      newpc = align_target(flush_target);
    end else if (consume && jump) begin
      newpc = align_target(jump_target);
    end else if (consume && branch_taken) begin
      newpc = align_target(branch_target);
    end else if (consume) begin
      // 32-bit modulo add: 32'hFFFFFFFC + 4 wraps to 0.
      newpc = pc + PC_STEP;
    end else begin
      newpc = pc;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer.
// Issues one fetch at a time to instruction memory at the current PC, holds
// the returned instruction until the core accepts it, and drives the PC
// register's next value (sequential, branch, jump, flush or reset vector).
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   pc / newpc                        : PC register current value / next value
//   imem_req_valid/addr/ready         : fetch request handshake
//   imem_resp_valid/data              : fetch response
//   instr, instr_pc, instr_valid      : registered instruction to decode
//   stall                             : core cannot accept instr this cycle
//   branch_taken/target, jump/target  : redirects resolved for the presented instr
//   flush, flush_target               : pipeline-independent redirect
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] PC_STEP      = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] newpc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        flush,
  input  logic [31:0] flush_target
);

  state_e      state_q, state_d;
  logic        drop_q, drop_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        consume_s;
  logic        req_fire_s;

  assign imem_req_addr = pc;
  assign instr         = instr_q;
  assign instr_pc      = instr_pc_q;
  assign instr_valid   = instr_valid_q;

  // Flush overrides acceptance: a flushed instruction is never consumed.
  assign consume_s  = instr_valid_q & ~stall & ~flush;
  assign req_fire_s = imem_req_valid & imem_req_ready;

  // Request only in S_REQ; a flush cycle suppresses it so the next request uses the new pc.
  always_comb begin
    imem_req_valid = 1'b0;
    if (!rst && !flush && (state_q == S_REQ)) begin
      imem_req_valid = 1'b1;
    end else begin
      imem_req_valid = 1'b0;
    end
  end

  // Fetch FSM next-state and datapath next values.
  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    req_pc_d      = req_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      S_REQ: begin
        if (req_fire_s) begin
          req_pc_d = pc;
          state_d  = S_WAIT;
        end else begin
          state_d  = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (drop_q || flush) begin
            // Response belongs to a fetch that was redirected away.
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d       = imem_resp_data;
            instr_pc_d    = req_pc_q;
            instr_valid_d = 1'b1;
            state_d       = S_OUT;
          end
        end else if (flush) begin
          // Response still in flight: remember to discard it.
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      S_OUT: begin
        if (flush || consume_s) begin
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end else begin
          instr_valid_d = 1'b1;
        end
      end
      default: begin
        state_d       = S_REQ;
        drop_d        = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      drop_q        <= 1'b0;
      req_pc_q      <= 32'h0000_0000;
      instr_q       <= 32'h0000_0000;
      instr_pc_q    <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drop_q        <= drop_d;
      req_pc_q      <= req_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  next_pc_select #(
    .RESET_VECTOR (RESET_VECTOR),
    .PC_STEP      (PC_STEP)
  ) u_next_pc_select (
    .rst           (rst),
    .flush         (flush),
    .consume       (consume_s),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .flush_target  (flush_target),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .pc            (pc),
    .newpc         (newpc)
  );

endmodule
